// File: rtl/if_pc_fetch_pkg.sv
// Shared constants and types for the fetch-stage PC generator.
// ADEL is also consumed by the IF/ID register, which flags misaligned fetches.
package if_pc_fetch_pkg;

   localparam logic [31:0] PKG_RESET_PC = 32'h0000_3000;
   localparam logic [31:0] PKG_EXC_VEC  = 32'h0000_4180;
   // Instruction memory is based at the reset PC
   localparam logic [31:0] PKG_IMEM_BASE = PKG_RESET_PC;
   localparam int unsigned PKG_IMEM_AW   = 12;

   // ExcCode for address error on load/fetch
   localparam logic [4:0] ADEL = 5'd4;

   // Next-PC source, listed in priority order
   typedef enum logic [2:0] {
      SrcExc,
      SrcEret,
      SrcHold,
      SrcBr,
      SrcPend,
      SrcSeq
   } npc_sel_e;

   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_redirect_buf.sv
// Buffers a branch/jump redirect that resolves while fetch is stalled, so it can be
// applied on the first unstalled edge. A flush (exception/ERET) or reset drops it.
module if_redirect_buf (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_stall,
   input  logic        i_flush,
   input  logic        i_br_taken,
   input  logic [31:0] i_br_target,
   output logic        o_pend_vld,
   output logic [31:0] o_pend_tgt
);

   logic        r_pend_vld;
   logic [31:0] r_pend_tgt;

   // Capture during stall (latest redirect wins); any unstalled edge consumes or
   // supersedes the buffered target, so validity always clears there.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pend_vld <= 1'b0;
         r_pend_tgt <= 32'h0;
      end else if (i_flush) begin
         r_pend_vld <= 1'b0;
      end else if (i_stall) begin
         if (i_br_taken) begin
            r_pend_vld <= 1'b1;
            r_pend_tgt <= i_br_target;
         end
      end else begin
         r_pend_vld <= 1'b0;
      end
   end

   assign o_pend_vld = r_pend_vld;
   assign o_pend_tgt = r_pend_tgt;

endmodule

// File: rtl/if_pc_fetch.sv
// Fetch-stage PC generator feeding the IF/ID register.
// Optional performance counters are enabled by defining IF_PC_FETCH_PERF_EN.
// Targets are loaded unchanged; alignment faults are flagged downstream.
module if_pc_fetch
   import if_pc_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = PKG_RESET_PC,
   parameter logic [31:0] EXC_VEC  = PKG_EXC_VEC,
   parameter int unsigned IMEM_AW  = PKG_IMEM_AW
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               br_taken,
   input  logic [31:0]        br_target,
   input  logic               is_jump_d,
   input  logic               exc_req,
   input  logic               eret,
   input  logic [31:0]        epc,
   output logic [31:0]        PC_F,
   output logic [31:0]        PC4_F,
   output logic               isj_F,
   output logic [IMEM_AW-1:0] imem_addr
`ifdef IF_PC_FETCH_PERF_EN
   ,
   output logic [31:0]        fetch_cnt,
   output logic [31:0]        stall_cnt
`endif
);

   logic [31:0] r_pc;
   logic [31:0] w_pc_d;
   logic        w_flush;
   logic        w_pend_vld;
   logic [31:0] w_pend_tgt;
   npc_sel_e    w_sel;

   assign w_flush = exc_req | eret;

   if_redirect_buf u_redirect_buf (
      .clk        (clk),
      .reset      (reset),
      .i_stall    (stall),
      .i_flush    (w_flush),
      .i_br_taken (br_taken),
      .i_br_target(br_target),
      .o_pend_vld (w_pend_vld),
      .o_pend_tgt (w_pend_tgt)
   );

   // Next-PC source selection in strict priority order
   always_comb begin
      w_sel = SrcSeq;
      if (exc_req) begin
         w_sel = SrcExc;
      end else if (eret) begin
         w_sel = SrcEret;
      end else if (stall) begin
         w_sel = SrcHold;
      end else if (br_taken) begin
         w_sel = SrcBr;
      end else if (w_pend_vld) begin
         w_sel = SrcPend;
      end
   end

   // Next-PC mux
   always_comb begin
      w_pc_d = pc_plus4(r_pc);
      unique case (w_sel)
         SrcExc:  w_pc_d = EXC_VEC;
         SrcEret: w_pc_d = epc;
         SrcHold: w_pc_d = r_pc;
         SrcBr:   w_pc_d = br_target;
         SrcPend: w_pc_d = w_pend_tgt;
         SrcSeq:  w_pc_d = pc_plus4(r_pc);
         default: w_pc_d = pc_plus4(r_pc);
      endcase
   end

   // Architectural fetch PC register
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pc <= RESET_PC;
      end else begin
         r_pc <= w_pc_d;
      end
   end

   assign PC_F      = r_pc;
   assign PC4_F     = pc_plus4(r_pc);
   assign isj_F     = is_jump_d;
   // Word offset from the memory base; out-of-range PCs simply alias
   assign imem_addr = IMEM_AW'((r_pc - RESET_PC) >> 2);

`ifdef IF_PC_FETCH_PERF_EN
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_stall_cnt;

   // A flush counts as a fetch even when stall is raised, since the PC moves
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_fetch_cnt <= 32'h0;
         r_stall_cnt <= 32'h0;
      end else if (!stall || w_flush) begin
         r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end else begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign fetch_cnt = r_fetch_cnt;
   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_if_pc_fetch.sv
// Directed bench for if_pc_fetch: a table of per-cycle inputs with the PC expected
// after the edge, plus a hand-written long-stall sequence.
module tb_if_pc_fetch;

   typedef struct {
      logic        rst_n;
      logic        stall;
      logic        br;
      logic [31:0] tgt;
      logic        jd;
      logic        exc;
      logic        eret;
      logic [31:0] epc;
      logic [31:0] exp_pc;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic        is_jump_d;
   logic        exc_req;
   logic        eret;
   logic [31:0] epc;
   logic [31:0] PC_F;
   logic [31:0] PC4_F;
   logic        isj_F;
   logic [11:0] imem_addr;
`ifdef IF_PC_FETCH_PERF_EN
   logic [31:0] fetch_cnt;
   logic [31:0] stall_cnt;
   logic [31:0] m_fetch;
   logic [31:0] m_stall;
`endif

   int n_vec  = 0;
   int n_fail = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   if_pc_fetch dut (
      .clk      (clk),
      .reset    (reset),
      .stall    (stall),
      .br_taken (br_taken),
      .br_target(br_target),
      .is_jump_d(is_jump_d),
      .exc_req  (exc_req),
      .eret     (eret),
      .epc      (epc),
      .PC_F     (PC_F),
      .PC4_F    (PC4_F),
      .isj_F    (isj_F),
      .imem_addr(imem_addr)
`ifdef IF_PC_FETCH_PERF_EN
      ,
      .fetch_cnt(fetch_cnt),
      .stall_cnt(stall_cnt)
`endif
   );

   function automatic vec_t mk(input logic r, input logic s, input logic b,
                               input logic [31:0] t, input logic j, input logic x,
                               input logic e, input logic [31:0] ep,
                               input logic [31:0] pc);
      vec_t v;
      v.rst_n = r; v.stall = s; v.br = b; v.tgt = t; v.jd = j;
      v.exc = x; v.eret = e; v.epc = ep; v.exp_pc = pc;
      return v;
   endfunction

   function automatic logic [11:0] exp_imem(input logic [31:0] pc);
      logic [31:0] d;
      d = (pc - 32'h0000_3000) >> 2;
      return d[11:0];
   endfunction

   task automatic chk32(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] req);
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s vec %0d: got %h want %h", name, idx, act, req);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      @(negedge clk);
      reset = v.rst_n; stall = v.stall; br_taken = v.br; br_target = v.tgt;
      is_jump_d = v.jd; exc_req = v.exc; eret = v.eret; epc = v.epc;
`ifdef IF_PC_FETCH_PERF_EN
      if (!v.rst_n) begin
         m_fetch = 0; m_stall = 0;
      end else if (!v.stall || v.exc || v.eret) begin
         m_fetch = m_fetch + 1;
      end else begin
         m_stall = m_stall + 1;
      end
`endif
      @(posedge clk);
      #1;
      n_vec++;
      chk32("PC_F", idx, PC_F, v.exp_pc);
      chk32("PC4_F", idx, PC4_F, v.exp_pc + 32'd4);
      chk32("imem_addr", idx, {20'h0, imem_addr}, {20'h0, exp_imem(v.exp_pc)});
      chk32("isj_F", idx, {31'h0, isj_F}, {31'h0, v.jd});
`ifdef IF_PC_FETCH_PERF_EN
      chk32("fetch_cnt", idx, fetch_cnt, m_fetch);
      chk32("stall_cnt", idx, stall_cnt, m_stall);
`endif
   endtask

   initial begin
      reset = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
      is_jump_d = 1'b0; exc_req = 1'b0; eret = 1'b0; epc = 32'h0;
`ifdef IF_PC_FETCH_PERF_EN
      m_fetch = 0; m_stall = 0;
`endif
      //            rst stl br  tgt           jd exc ert epc           exp_pc
      vecs.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_3000));
      vecs.push_back(mk(0, 0, 0, 32'h0,        1, 0, 0, 32'h0,        32'h0000_3000));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_3004));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_3008));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_300C));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_3010));
      // live redirect
      vecs.push_back(mk(1, 0, 1, 32'h0000_3400, 0, 0, 0, 32'h0,        32'h0000_3400));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_3404));
      vecs.push_back(mk(1, 0, 1, 32'h0000_3020, 1, 0, 0, 32'h0,        32'h0000_3020));
      // buffered redirect, second one overwrites the first
      vecs.push_back(mk(1, 1, 1, 32'h0000_3500, 1, 0, 0, 32'h0,        32'h0000_3020));
      vecs.push_back(mk(1, 1, 1, 32'h0000_3600, 0, 0, 0, 32'h0,        32'h0000_3020));
      vecs.push_back(mk(1, 1, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_3020));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_3600));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_3604));
      // exception beats stall and drops the pending redirect
      vecs.push_back(mk(1, 1, 1, 32'h0000_3700, 0, 0, 0, 32'h0,        32'h0000_3604));
      vecs.push_back(mk(1, 1, 0, 32'h0,        0, 1, 0, 32'h0,        32'h0000_4180));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_4184));
      // eret beats branch
      vecs.push_back(mk(1, 0, 1, 32'h0000_3200, 0, 0, 1, 32'h0000_3088, 32'h0000_3088));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_308C));
      // reset mid-stall discards pending redirect
      vecs.push_back(mk(1, 1, 1, 32'h0000_3300, 0, 0, 0, 32'h0,        32'h0000_308C));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_3000));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_3004));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_3008));
      // eret beats stall; exception beats eret
      vecs.push_back(mk(1, 1, 0, 32'h0,        0, 0, 1, 32'h0000_3100, 32'h0000_3100));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 1, 1, 32'h0000_3200, 32'h0000_4180));
      // live redirect beats buffered
      vecs.push_back(mk(1, 1, 1, 32'h0000_3700, 0, 0, 0, 32'h0,        32'h0000_4180));
      vecs.push_back(mk(1, 0, 1, 32'h0000_3800, 0, 0, 0, 32'h0,        32'h0000_3800));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_3804));
      // wrap and misaligned target
      vecs.push_back(mk(1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'h0,        32'hFFFF_FFFC));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_0000));
      vecs.push_back(mk(1, 0, 1, 32'h0000_3002, 1, 0, 0, 32'h0,        32'h0000_3002));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        32'h0000_3006));

      foreach (vecs[i]) run_vec(vecs[i], i);

      // Long stall with a redirect in its second cycle; PC must hold throughout
      for (int k = 0; k < 4; k++) begin
         run_vec(mk(1, 1, (k == 1), 32'h0000_3ABC, 0, 0, 0, 32'h0, 32'h0000_3006), 100 + k);
      end
      run_vec(mk(1, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0000_3ABC), 104);
      run_vec(mk(1, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0000_3AC0), 105);

      // Reset again and check the reset state
      run_vec(mk(0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0000_3000), 106);
      if (imem_addr !== 12'h000) begin
         n_fail++;
         $display("FAIL imem_addr_reset: got %h want 000", imem_addr);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/if_pc_fetch.md
Name: if_pc_fetch

Overview:
- Fetch-stage PC generator. It sits directly upstream of the IF/ID pipeline register.
- Holds the architectural fetch PC and drives the instruction-memory word address.
- Produces PC_F, PC4_F and isj_F, which the IF/ID register latches when its WE is high.
- Arbitrates the next PC between exception vector, ERET return, branch/jump redirect, a buffered redirect captured during stall, and sequential PC+4.

Parameters:
RESET_PC  32'h0000_3000  PC value loaded on reset
EXC_VEC   32'h0000_4180  exception handler entry address
IMEM_AW   12             instruction-memory word-address width (4096 words)

Ports:
clk          in   1        single system clock; all state updates on posedge
reset        in   1        synchronous, active-low reset (0 at posedge clears state)
stall        in   1        hazard stall from ID; 1 = hold PC (same signal that drives IF/ID WE low)
br_taken     in   1        branch/jump in ID resolved taken this cycle
br_target    in   32       redirect target, valid when br_taken=1
is_jump_d    in   1        instruction currently in ID is a branch/jump (fetched instr is a delay slot)
exc_req      in   1        exception/interrupt accepted; redirect to EXC_VEC
eret         in   1        ERET committed; redirect to epc
epc          in   32       CP0 EPC value, valid with eret
PC_F         out  32       current fetch PC
PC4_F        out  32       PC_F + 4 (mod 2^32), combinational
isj_F        out  1        fetched instruction is in a delay slot
imem_addr    out  IMEM_AW  (PC_F - RESET_PC) >> 2, truncated to IMEM_AW bits, combinational

Behaviour:
- State:
  - pc_q (32b)
  - pend_vld (1b)
  - pend_tgt (32b)
  - optional counters
- Reset (reset==0 at posedge):
  - pc_q = RESET_PC
  - pend_vld = 0, pend_tgt = 0
  - counters = 0
  - Resulting outputs:
    - PC_F = 0x3000
    - PC4_F = 0x3004
    - imem_addr = 0
    - isj_F = is_jump_d (combinational)
  - Reset overrides every other input.
- Next-PC priority, evaluated at each posedge when reset==1:
  1. exc_req=1: pc_q <= EXC_VEC; pend_vld <= 0. Overrides stall, eret and br_taken.
  2. eret=1: pc_q <= epc; pend_vld <= 0. Overrides stall and br_taken.
  3. stall=1:
     - pc_q holds.
     - If br_taken=1: pend_vld <= 1, pend_tgt <= br_target. A later br_taken during the same stall overwrites the buffered target.
  4. stall=0 and br_taken=1: pc_q <= br_target; pend_vld <= 0. A live redirect beats a buffered one.
  5. stall=0 and pend_vld=1: pc_q <= pend_tgt; pend_vld <= 0.
  6. Otherwise: pc_q <= pc_q + 4 (wraps 0xFFFF_FFFC -> 0x0000_0000).
- Latency:
  - Redirect inputs take effect on PC_F one cycle after the sampling edge.
  - The buffered redirect is applied on the first non-stall edge.
- isj_F = is_jump_d, combinational.
- No alignment or range checking here; the IF/ID register flags AdEL (ExcCode 4).
  - Misaligned or out-of-range targets are loaded unchanged.
  - imem_addr simply truncates.
- Reset asserted mid-stall with pend_vld=1: pending redirect is discarded.

Optional Feature:
- Macro: IF_PC_FETCH_PERF_EN
- Defined:
  - Adds outputs fetch_cnt[31:0] and stall_cnt[31:0], both reset to 0.
  - fetch_cnt increments on each non-reset posedge where stall=0 or exc_req=1 or eret=1.
  - stall_cnt increments when stall=1 and neither exc_req nor eret is asserted.
  - Both wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour is identical.

Decomposition:
- Shared package/header holds RESET_PC, EXC_VEC and IMEM base constants, plus ExcCode constant ADEL=4 (shared with IF/ID).
- One sub-module is natural: if_redirect_buf, the pend_vld/pend_tgt capture/consume logic.
- Next-PC mux stays in the top module.

Test Plan:
- Reset low 2 cycles, then high 3 cycles, no other inputs -> PC_F 0x3000, 0x3004, 0x3008, 0x300C; imem_addr 0, 1, 2, 3.
- At PC_F=0x3010 pulse br_taken=1 with br_target=0x3400, stall=0 -> next PC_F=0x3400, then 0x3404.
- At PC_F=0x3020:
  - stall=1 for 3 cycles; br_taken with target 0x3500 in the 1st stall cycle, 0x3600 in the 2nd.
  - Required: PC_F stays 0x3020; on first unstalled edge PC_F=0x3600; pend_vld cleared.
- stall=1 plus exc_req=1 in the same cycle, pend_vld=1 -> PC_F=0x4180 next cycle; pending dropped; the following cycle PC_F=0x4184 with stall=0.
- eret=1 with epc=0x3088 and br_taken=1 with target 0x3200 simultaneously -> PC_F=0x3088.
- pend_vld=1 during stall, then reset low for one edge -> PC_F=0x3000; after release PC_F=0x3004 (no stale redirect). With IF_PC_FETCH_PERF_EN defined, fetch_cnt=0 and stall_cnt=0 after reset.
